// File: rtl/nibble_packer.sv
// -----------------------------------------------------------------------------
// nibble_packer
//
// Purpose:
//   Drains a show-ahead 4-bit FIFO one nibble per cycle. Each group of NIBBLES
//   nibbles is packed LSB-first into one word, and the word is presented on a
//   registered valid/ready output. A flush pulse emits a partly filled word,
//   zero-padded above the valid nibbles, together with its nibble count. This
//   lets a short burst drain without waiting for more data.
//
// Parameters:
//   NIBBLES  nibbles per output word, legal range 2..8
//   CW       width of out_count, derived as $clog2(NIBBLES+1)
//
// Ports:
//   clk             clock, every flop is updated on the rising edge
//   rstN            synchronous active-low reset
//   fifo_empty      FIFO empty flag
//   fifo_read_data  FIFO head nibble, valid whenever fifo_empty=0
//   fifo_read_en    pop strobe (combinational), the FIFO advances on the same edge
//   out_data        assembled word, nibble 0 is in bits [3:0]
//   out_count       number of valid nibbles in out_data
//   out_valid       out_data/out_count hold a word
//   out_ready       downstream takes the word when out_valid && out_ready
//   flush           single-cycle request to emit the partial word
//   out_parity      only when NIBBLE_PACKER_PARITY_EN is defined: XOR of out_data
//
// Build option:
//   NIBBLE_PACKER_PARITY_EN  adds the registered out_parity output
// -----------------------------------------------------------------------------
module nibble_packer #(
  parameter int NIBBLES = 2,
  localparam int CW = $clog2(NIBBLES + 1)
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 fifo_empty,
  input  logic [3:0]           fifo_read_data,
  output logic                 fifo_read_en,
  output logic [4*NIBBLES-1:0] out_data,
  output logic [CW-1:0]        out_count,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 flush
`ifdef NIBBLE_PACKER_PARITY_EN
  ,
  output logic                 out_parity
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  asm_q, asm_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [CW-1:0] out_count_q, out_count_d;
  logic          out_valid_q, out_valid_d;

  logic          slot_free;
  logic          pop;
  logic          flush_emit;
  logic [W-1:0]  asm_with_new;

`ifdef NIBBLE_PACKER_PARITY_EN
  logic          out_parity_q, out_parity_d;

  // Even parity over a whole output word.
  function automatic logic word_parity(input logic [W-1:0] word);
    return ^word;
  endfunction
`endif

  // The output register can take a new word if it is empty or being accepted.
  assign slot_free = !out_valid_q || out_ready;

  // State register: FSM state plus the whole datapath, synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q     <= ST_FILL;
      idx_q       <= '0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
`ifdef NIBBLE_PACKER_PARITY_EN
      out_parity_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
`ifdef NIBBLE_PACKER_PARITY_EN
      out_parity_q <= out_parity_d;
`endif
    end
  end

  // Next-state logic: a flush with nothing assembled is dropped, and the
  // flush state is left once the partial word has a free output slot.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (flush && (idx_q != '0)) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_FLUSH: begin
        if (slot_free) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // FSM outputs: the pop strobe and the partial-word emit strobe.
  // The last nibble of a word is only popped when the word has somewhere to
  // go, so a word is never overwritten while it waits.
  always_comb begin
    pop        = 1'b0;
    flush_emit = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (rstN && !fifo_empty && !flush &&
            !((idx_q == LAST_IDX) && !slot_free)) begin
          pop = 1'b1;
        end else begin
          pop = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (slot_free) begin
          flush_emit = 1'b1;
        end else begin
          flush_emit = 1'b0;
        end
      end
      default: begin
        pop        = 1'b0;
        flush_emit = 1'b0;
      end
    endcase
  end

  assign fifo_read_en = pop;

  // Datapath: nibble insertion, word completion and partial-word emission.
  always_comb begin
    asm_with_new = asm_q;
    asm_with_new[{idx_q, 2'b00} +: 4] = fifo_read_data;

    idx_d       = idx_q;
    asm_d       = asm_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
`ifdef NIBBLE_PACKER_PARITY_EN
    out_parity_d = out_parity_q;
`endif

    // An accepted word leaves; a load below at the same edge overrides this.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (pop) begin
      if (idx_q != LAST_IDX) begin
        asm_d = asm_with_new;
        idx_d = idx_q + IW'(1);
      end else begin
        out_data_d  = asm_with_new;
        out_count_d = CW'(NIBBLES);
        out_valid_d = 1'b1;
        idx_d       = '0;
        asm_d       = '0;
`ifdef NIBBLE_PACKER_PARITY_EN
        out_parity_d = word_parity(asm_with_new);
`endif
      end
    end else if (flush_emit) begin
      // Unused upper nibbles are already zero because asm is cleared per word.
      out_data_d  = asm_q;
      out_count_d = CW'(idx_q);
      out_valid_d = 1'b1;
      idx_d       = '0;
      asm_d       = '0;
`ifdef NIBBLE_PACKER_PARITY_EN
      out_parity_d = word_parity(asm_q);
`endif
    end else begin
      idx_d = idx_q;
      asm_d = asm_q;
    end
  end

  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_valid = out_valid_q;

`ifdef NIBBLE_PACKER_PARITY_EN
  assign out_parity = out_parity_q;
`else
  // Parity output not built in this configuration.
`endif

endmodule

// File: doc/nibble_packer.md
# nibble_packer

Downstream consumer of the 4-bit write/read FIFO. Pops nibbles whenever the FIFO is non-empty, assembles NIBBLES consecutive nibbles LSB-first into one output word, and presents the word on a registered valid/ready interface to the next stage. A flush request emits a partially assembled word, zero-padded, with a nibble count. This lets bursts that do not fill a word drain without waiting for more data.

## Interface
- NIBBLES, 2: nibbles per output word; legal range 2..8.
- CW, $clog2(NIBBLES+1): width of out_count (derived, not overridden).
- clk  in  1  clock; all logic on posedge.
- rstN  in  1  synchronous, active-low reset, sampled on posedge clk.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read_data  in  4  FIFO head nibble; valid whenever fifo_empty=0 (show-ahead).
- fifo_read_en  out  1  pop strobe (combinational); the FIFO advances at the same edge.
- out_data  out  4*NIBBLES  assembled word; nibble 0 in bits [3:0].
- out_count  out  CW  number of valid nibbles in out_data (NIBBLES, or fewer after a flush).
- out_valid  out  1  out_data/out_count valid.
- out_ready  in  1  downstream accepts the word when out_valid && out_ready at posedge.
- flush  in  1  single-cycle request to emit the partial word.
- out_parity  out  1  present only with NIBBLE_PACKER_PARITY_EN; XOR of out_data.

## Operation
- Internal state:
  - assembly register asm (4*NIBBLES bits);
  - index idx (0..NIBBLES-1);
  - FSM state ST_FILL / ST_FLUSH.
- Output slot free: slot_free = !out_valid || out_ready.
- fifo_read_en = rstN && !fifo_empty && state==ST_FILL && !flush && !(idx==NIBBLES-1 && !slot_free).
- On a pop:
  - fifo_read_data is written to asm nibble idx.
  - If idx<NIBBLES-1: idx++.
  - Else the completed word (asm with the new nibble) loads into out_data, out_count=NIBBLES, out_valid=1, idx=0, and asm is cleared.
- ST_FILL -> ST_FLUSH: flush=1 and idx!=0. Flush with idx==0 is dropped. No pop occurs in the flush cycle.
- ST_FLUSH:
  - No pops.
  - When slot_free: out_data=asm (unused upper nibbles 0), out_count=idx, out_valid=1, idx=0, asm cleared, return to ST_FILL.
  - Further flush pulses while in ST_FLUSH are ignored.
- Handshake:
  - out_valid clears on an accept unless a new word loads at the same edge.
  - out_data and out_count are held stable while out_valid && !out_ready.
  - A word is never dropped or duplicated.
- Reset (rstN=0 at posedge), including mid-word:
  - out_data=0, out_count=0, out_valid=0, out_parity=0, idx=0, asm=0, state=ST_FILL.
  - Partial nibbles are discarded.
  - fifo_read_en=0 while rstN=0.

## Timing
- Pop-to-word latency: out_valid rises at the edge that pops the last nibble of the word.
- Throughput:
  - One nibble per cycle.
  - With out_ready=1 and the FIFO non-empty, one word per NIBBLES cycles with no bubbles.
  - Accept and load in the same cycle are allowed.
- Backpressure: with out_valid=1 and out_ready=0, pops continue until idx==NIBBLES-1, then stall until out_ready.
- Flush latency: the partial word appears at the earliest edge after the flush cycle at which slot_free=1; minimum one cycle later.
- fifo_empty/fifo_read_data are sampled combinationally. The block never pops when fifo_empty=1.

## Configuration
- NIBBLE_PACKER_PARITY_EN defined:
  - Port out_parity exists.
  - It is registered alongside out_data (^ of the loaded word), with the same hold and reset behaviour (reset 0).
- NIBBLE_PACKER_PARITY_EN undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset: hold rstN=0 for 2 cycles with fifo_empty=0 -> fifo_read_en=0 and out_valid/out_data/out_count all 0.
- Stream (NIBBLES=2, out_ready=1): FIFO supplies 1,2,3,4 -> out_data 0x21 (count 2), then 0x43 on consecutive word slots, with no gaps.
- Backpressure: out_ready=0 and FIFO supplies 1,2,3,4,5 -> 0x21 held; nibble 3 popped; fifo_read_en=0 with 4 at the head. Raise out_ready -> 0x21 accepted, next word 0x43.
- Flush: pop 0xA, then pulse flush -> out_data=0x0A, out_count=1, no pop in the flush cycle. A flush with idx=0 produces no word.
- Empty/reset mid-word: fifo_empty=1 -> fifo_read_en never 1. Pop 0x7, then assert rstN=0 -> no word is emitted and the next word built from 1,2 is 0x21.
- Parity (macro defined): word 0x21 -> out_parity=0; word 0x43 -> out_parity=1.
